// File: rtl/jtgng_objscan.sv
// Object scanner: walks every object slot of the sprite table once per
// active line, PXLMAX+1 pixel clocks per object, gated by a per-line
// timing PROM (SEATM_b enables the scan, DISPTM_b is passed through).
module jtgng_objscan #(
  parameter int OBJW = 5,
  parameter int PXLW = 4,
  parameter int VW   = 8
) (
  input  logic            rst,
  input  logic            clk,
  input  logic            cen,
  input  logic [VW-1:0]   V,
  input  logic            HINIT,
  input  logic            mode_desc,
  output logic [PXLW-1:0] pxlcnt,
  output logic [OBJW-1:0] objcnt,
  output logic            line,
  output logic            busy,
  output logic            obj_start,
  output logic            done,
  output logic            SEATM_b,
  output logic            DISPTM_b,
  input  logic [VW-1:0]   prog_addr,
  input  logic            prog_we,
  input  logic [1:0]      prog_din
);

  localparam logic [OBJW-1:0] OBJMAX = '1;
  localparam logic [PXLW-1:0] PXLMAX = '1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state_reg, state_next;
  logic [PXLW-1:0] pxl_reg, pxl_next;
  logic [OBJW-1:0] obj_reg, obj_next;
  logic            line_reg, line_next;
  logic            done_reg, done_next;
  logic            desc_reg, desc_next;
  logic [1:0]      prom_reg;
  logic [OBJW-1:0] last_obj;

  // Timing PROM storage; blank (all ones) until loaded through the prog port.
  logic [1:0] mem [0:(2**VW)-1] = '{default: 2'b11};

  // PROM load port: free-running, untouched by reset or the pixel enable.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_din;
  end

  // PROM read register: one pixel clock of latency; a coincident write is
  // not visible until the following read.
  always_ff @(posedge clk) begin
    if (rst)      prom_reg <= 2'b11;
    else if (cen) prom_reg <= mem[V];
  end

  assign SEATM_b  = prom_reg[0];
  assign DISPTM_b = prom_reg[1];

  // The final object depends on the scan direction latched at line start.
  assign last_obj = desc_reg ? '0 : OBJMAX;

  // Scan state registers, advanced once per pixel clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pxl_reg   <= '0;
      obj_reg   <= '0;
      line_reg  <= 1'b0;
      done_reg  <= 1'b0;
      desc_reg  <= 1'b0;
    end else if (cen) begin
      state_reg <= state_next;
      pxl_reg   <= pxl_next;
      obj_reg   <= obj_next;
      line_reg  <= line_next;
      done_reg  <= done_next;
      desc_reg  <= desc_next;
    end
  end

  // Next-state logic: line start wins over pixel/object stepping and completion.
  always_comb begin
    state_next = state_reg;
    pxl_next   = pxl_reg;
    obj_next   = obj_reg;
    line_next  = line_reg;
    done_next  = 1'b0;
    desc_next  = desc_reg;
    if (HINIT) begin
      pxl_next   = '0;
      obj_next   = mode_desc ? OBJMAX : '0;
      line_next  = ~line_reg;
      state_next = SEATM_b ? IDLE : SCAN;
      desc_next  = mode_desc;
    end else if (state_reg == SCAN) begin
      if (pxl_reg != PXLMAX) begin
        pxl_next = pxl_reg + 1'b1;
      end else if (obj_reg != last_obj) begin
        pxl_next = '0;
        obj_next = desc_reg ? obj_reg - 1'b1 : obj_reg + 1'b1;
      end else begin
        pxl_next   = '0;
        state_next = IDLE;
        done_next  = 1'b1;
      end
    end
  end

  assign pxlcnt    = pxl_reg;
  assign objcnt    = obj_reg;
  assign line      = line_reg;
  assign busy      = (state_reg == SCAN);
  assign done      = done_reg;
  assign obj_start = busy & (pxl_reg == '0);

endmodule

// File: tb/tb_jtgng_objscan.sv
// Directed bench for jtgng_objscan with default parameters.
module tb_jtgng_objscan;

  logic       rst, clk, cen, HINIT, mode_desc, prog_we;
  logic [7:0] V, prog_addr;
  logic [1:0] prog_din;
  logic [3:0] pxlcnt;
  logic [4:0] objcnt;
  logic       line, busy, obj_start, done, SEATM_b, DISPTM_b;

  int checks   = 0;
  int failures = 0;

  jtgng_objscan dut (
    .rst(rst), .clk(clk), .cen(cen), .V(V), .HINIT(HINIT),
    .mode_desc(mode_desc), .pxlcnt(pxlcnt), .objcnt(objcnt), .line(line),
    .busy(busy), .obj_start(obj_start), .done(done), .SEATM_b(SEATM_b),
    .DISPTM_b(DISPTM_b), .prog_addr(prog_addr), .prog_we(prog_we),
    .prog_din(prog_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int   starts;
  logic seen_done;
  logic frozen_ok;
  logic [15:0] snap;

  initial begin
    rst = 1; cen = 1; HINIT = 0; mode_desc = 0; V = 8'h00;
    prog_we = 0; prog_addr = 0; prog_din = 0;

    // Load the PROM with zeros while held in reset.
    #1;
    for (int a = 0; a < 256; a++) begin
      prog_we = 1; prog_addr = 8'(a); prog_din = 2'b00;
      tick();
    end
    prog_we = 0;
    chk("rst_pxlcnt", 32'(pxlcnt), 0);
    chk("rst_objcnt", 32'(objcnt), 0);
    chk("rst_line", 32'(line), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_seatm", 32'(SEATM_b), 1);
    chk("rst_disptm", 32'(DISPTM_b), 1);

    rst = 0;
    tick();
    chk("prom_v0_seatm", 32'(SEATM_b), 0);

    // Ascending full scan.
    HINIT = 1; tick(); HINIT = 0;
    chk("asc_start_busy", 32'(busy), 1);
    chk("asc_start_line", 32'(line), 1);
    starts = obj_start ? 1 : 0;
    seen_done = 0;
    for (int i = 1; i <= 512; i++) begin
      tick();
      if (i < 512) begin
        starts += obj_start ? 1 : 0;
        if (done) seen_done = 1;
      end
      if (i == 16)  chk("asc_t16_obj", 32'({objcnt, pxlcnt}), 32'({5'd1, 4'd0}));
      if (i == 511) chk("asc_t511_obj", 32'({objcnt, pxlcnt, busy}), 32'({5'd31, 4'd15, 1'b1}));
    end
    chk("asc_no_early_done", 32'(seen_done), 0);
    chk("asc_done", 32'({done, busy, objcnt, pxlcnt}), 32'({1'b1, 1'b0, 5'd31, 4'd0}));
    chk("asc_obj_starts", 32'(starts), 32);
    tick();
    chk("asc_done_clear", 32'({done, busy, objcnt}), 32'({1'b0, 1'b0, 5'd31}));

    // Descending scan, direction input toggled mid-line.
    mode_desc = 1; HINIT = 1; tick(); HINIT = 0;
    chk("desc_start", 32'({objcnt, pxlcnt, line, busy}), 32'({5'd31, 4'd0, 1'b0, 1'b1}));
    for (int i = 1; i <= 512; i++) begin
      if (i == 5) mode_desc = 0;
      if (i == 300) mode_desc = 1;
      if (i == 400) mode_desc = 0;
      tick();
      if (i == 16)  chk("desc_t16_obj", 32'(objcnt), 30);
      if (i == 32)  chk("desc_t32_obj", 32'(objcnt), 29);
      if (i == 511) chk("desc_t511", 32'({objcnt, pxlcnt, done}), 32'({5'd0, 4'd15, 1'b0}));
    end
    chk("desc_done", 32'({done, busy, objcnt}), 32'({1'b1, 1'b0, 5'd0}));
    tick();
    chk("desc_done_clear", 32'(done), 0);

    // Line start every 384 pixel clocks: scan never completes.
    mode_desc = 0;
    seen_done = 0;
    for (int l = 0; l < 2; l++) begin
      HINIT = 1; tick(); HINIT = 0;
      chk("short_start", 32'({objcnt, pxlcnt, busy, line}), 32'({5'd0, 4'd0, 1'b1, (l == 0) ? 1'b1 : 1'b0}));
      for (int i = 1; i <= 383; i++) begin
        tick();
        if (done) seen_done = 1;
      end
      chk("short_end", 32'({objcnt, pxlcnt}), 32'({5'd23, 4'd15}));
    end
    HINIT = 1; tick(); HINIT = 0;
    chk("short_restart", 32'({objcnt, pxlcnt, line}), 32'({5'd0, 4'd0, 1'b1}));
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (done) seen_done = 1;
    end
    chk("short_no_done", 32'(seen_done), 0);
    chk("mid_scan", 32'({objcnt, pxlcnt}), 32'({5'd6, 4'd4}));

    // Pixel enable held low: everything frozen, even with HINIT high.
    snap = {pxlcnt, objcnt, line, busy, done, SEATM_b, DISPTM_b, obj_start};
    frozen_ok = 1;
    cen = 0; HINIT = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({pxlcnt, objcnt, line, busy, done, SEATM_b, DISPTM_b, obj_start} !== snap) frozen_ok = 0;
    end
    chk("cen_freeze", 32'(frozen_ok), 1);
    HINIT = 0; cen = 1;
    tick();
    chk("cen_resume", 32'({objcnt, pxlcnt}), 32'({5'd6, 4'd5}));

    // Reset mid-scan: immediate reset values, no done afterwards.
    rst = 1; tick(); rst = 0;
    chk("rst_mid", 32'({pxlcnt, objcnt, line, busy, done, SEATM_b, DISPTM_b}),
        32'({4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}));
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done | busy) seen_done = 1;
    end
    chk("rst_mid_quiet", 32'(seen_done), 0);

    // PROM write: coincident read returns old data, next read returns new.
    V = 8'h10; prog_addr = 8'h10; prog_din = 2'b01; prog_we = 1;
    tick();
    prog_we = 0;
    chk("prom_old_data", 32'({DISPTM_b, SEATM_b}), 32'(2'b00));
    tick();
    chk("prom_new_data", 32'({DISPTM_b, SEATM_b}), 32'(2'b01));
    HINIT = 1; tick(); HINIT = 0;
    chk("prom_blank_line", 32'({busy, line, pxlcnt, objcnt}), 32'({1'b0, 1'b1, 4'd0, 5'd0}));
    tick(); tick();
    chk("prom_blank_hold", 32'({busy, done, pxlcnt}), 32'({1'b0, 1'b0, 4'd0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
